// File: rtl/demux4_buf_if.sv
// Handshake bundle for demux4_buf: one steered input stream, four buffered output channels.
interface demux4_buf_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );
endinterface

// File: rtl/demux4_buf.sv
// 1-to-4 demultiplexer with an independent 2-entry FIFO per channel.
// Heads are held in registers so out_dataK keeps its last word once a channel drains.
module demux4_buf #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    demux4_buf_if.slave  bus
);
    logic [7:0]         count_flat;
    logic [3:0]         valid_flat;
    logic [4*WIDTH-1:0] data_flat;
    logic               in_ready_int;

    // in_ready depends only on registered occupancy, in_sel and flush
    assign in_ready_int = (count_flat[{bus.in_sel, 1'b0} +: 2] < 2'd2) & ~flush;
    assign bus.in_ready = in_ready_int;
    assign bus.out_valid = valid_flat;
    assign bus.out_data0 = data_flat[0*WIDTH +: WIDTH];
    assign bus.out_data1 = data_flat[1*WIDTH +: WIDTH];
    assign bus.out_data2 = data_flat[2*WIDTH +: WIDTH];
    assign bus.out_data3 = data_flat[3*WIDTH +: WIDTH];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [1:0]       count_reg, count_next;
            logic             rd_reg, rd_next;
            logic             wr_reg, wr_next;
            logic [WIDTH-1:0] mem_reg [2];
            logic [WIDTH-1:0] data_reg, data_next;
            logic             push, pop;

            assign push = bus.in_valid & in_ready_int & (bus.in_sel == 2'(gi));
            assign pop  = (count_reg != 2'd0) & bus.out_ready[gi] & ~flush;

            assign count_flat[gi*2 +: 2]       = count_reg;
            assign valid_flat[gi]              = (count_reg != 2'd0);
            assign data_flat[gi*WIDTH +: WIDTH] = data_reg;

            always_comb begin
                count_next = count_reg;
                rd_next    = rd_reg;
                wr_next    = wr_reg;
                data_next  = data_reg;
                if (flush) begin
                    count_next = 2'd0;
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                end else begin
                    count_next = count_reg + 2'(push) - 2'(pop);
                    rd_next    = rd_reg ^ pop;
                    wr_next    = wr_reg ^ push;
                    // Next head is the incoming word when it lands in the slot being read next
                    if (count_next != 2'd0) begin
                        if (push && (wr_reg == rd_next)) begin
                            data_next = bus.in_data;
                        end else begin
                            data_next = mem_reg[rd_next];
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg  <= 2'd0;
                    rd_reg     <= 1'b0;
                    wr_reg     <= 1'b0;
                    data_reg   <= '0;
                    mem_reg[0] <= '0;
                    mem_reg[1] <= '0;
                end else begin
                    count_reg <= count_next;
                    rd_reg    <= rd_next;
                    wr_reg    <= wr_next;
                    data_reg  <= data_next;
                    if (push) begin
                        mem_reg[wr_reg] <= bus.in_data;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_demux4_buf.sv
// Randomized and directed bench for demux4_buf against a queue-based reference model.
module tb_demux4_buf;
    logic clk;
    logic rst_n;
    logic flush;
    int   n_vec;
    int   n_err;

    demux4_buf_if #(.WIDTH(8)) bus ();

    demux4_buf #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one queue per channel plus the last head each channel showed
    logic [7:0] q [4][$];
    logic [7:0] last_head [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                last_head[k] = 8'h00;
            end
        end else if (flush) begin
            for (int k = 0; k < 4; k++) q[k].delete();
        end else begin
            bit accept;
            accept = bus.in_valid && (q[bus.in_sel].size() < 2);
            for (int k = 0; k < 4; k++)
                if (q[k].size() > 0 && bus.out_ready[k]) void'(q[k].pop_front());
            if (accept) q[bus.in_sel].push_back(bus.in_data);
            for (int k = 0; k < 4; k++)
                if (q[k].size() > 0) last_head[k] = q[k][0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [3:0] ev;
        logic [7:0] od [4];
        od[0] = bus.out_data0;
        od[1] = bus.out_data1;
        od[2] = bus.out_data2;
        od[3] = bus.out_data3;
        for (int k = 0; k < 4; k++) ev[k] = (q[k].size() > 0);
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        for (int k = 0; k < 4; k++)
            chk($sformatf("out_data%0d", k), 32'(od[k]), 32'(last_head[k]));
        chk("in_ready", 32'(bus.in_ready),
            32'((q[bus.in_sel].size() < 2) && !flush));
    end

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] d,
                         input logic [3:0] ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_flush();
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
        step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_data0", 32'(bus.out_data0), 32'h0);

        // Latency and order on channel 2
        drive(1'b1, 2'd2, 8'hA1, 4'b0000, 1'b0);
        step();
        chk("lat_valid", 32'(bus.out_valid), 32'b0100);
        chk("lat_data2", 32'(bus.out_data2), 32'hA1);
        drive(1'b1, 2'd2, 8'hA2, 4'b0000, 1'b0);
        step();
        drive(1'b0, 2'd2, 8'h00, 4'b0000, 1'b0);
        #1 chk("full_ready2", 32'(bus.in_ready), 32'h0);
        drive(1'b0, 2'd2, 8'h00, 4'b0100, 1'b0);
        step();
        chk("order_second", 32'(bus.out_data2), 32'hA2);
        step();
        chk("drained_valid", 32'(bus.out_valid), 32'h0);
        chk("drained_hold", 32'(bus.out_data2), 32'hA2);

        // Full channel refuses a push even while popping
        do_flush();
        drive(1'b1, 2'd1, 8'h11, 4'b0000, 1'b0); step();
        drive(1'b1, 2'd1, 8'h22, 4'b0000, 1'b0); step();
        drive(1'b1, 2'd1, 8'h55, 4'b0010, 1'b0);
        #1 chk("full_pop_ready", 32'(bus.in_ready), 32'h0);
        step();
        chk("full_pop_head", 32'(bus.out_data1), 32'h22);
        drive(1'b1, 2'd1, 8'h55, 4'b0000, 1'b0); step();
        drive(1'b0, 2'd1, 8'h00, 4'b0010, 1'b0); step();
        chk("full_pop_follow", 32'(bus.out_data1), 32'h55);

        // Concurrent push and pops
        do_flush();
        drive(1'b1, 2'd0, 8'h10, 4'b0000, 1'b0); step();
        drive(1'b1, 2'd3, 8'h30, 4'b0000, 1'b0); step();
        drive(1'b1, 2'd0, 8'h77, 4'b1001, 1'b0); step();
        chk("conc_valid", 32'(bus.out_valid), 32'b0001);
        chk("conc_data0", 32'(bus.out_data0), 32'h77);

        // Isolation while channel 0 is full
        do_flush();
        drive(1'b1, 2'd0, 8'hC0, 4'b0000, 1'b0); step();
        drive(1'b1, 2'd0, 8'hC1, 4'b0000, 1'b0); step();
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 2'(k), 8'(8'hD0 + k), 4'b0000, 1'b0);
            #1 chk("iso_ready", 32'(bus.in_ready), 32'h1);
            step();
        end
        chk("iso_valid", 32'(bus.out_valid), 32'b1111);
        chk("iso_data0", 32'(bus.out_data0), 32'hC0);

        // Flush discards buffered data and the concurrent push
        drive(1'b1, 2'd0, 8'hEE, 4'b0000, 1'b1);
        #1 chk("flush_ready", 32'(bus.in_ready), 32'h0);
        step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);

        // Asynchronous reset mid-cycle with data buffered
        drive(1'b1, 2'd1, 8'h9A, 4'b0000, 1'b0); step();
        drive(1'b1, 2'd3, 8'h9B, 4'b0000, 1'b0); step();
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_data1", 32'(bus.out_data1), 32'h0);
        chk("arst_data3", 32'(bus.out_data3), 32'h0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 8'h01, 4'b0000, 1'b0);
        #1 chk("arst_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("arst_fresh", 32'(bus.out_data3), 32'h01);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom), ($urandom_range(0, 24) == 0));
            step();
        end
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
